// File: rtl/float_add_arb.sv
`default_nettype none
// ============================================================================
// Module   : float_add_arb
// Brief    : Two-requester round-robin front end for a shared pipelined
//            float adder, with in-order tagged result return.
// Revision : 1.0
// ============================================================================
module float_add_arb #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,

    output logic [31:0] fa_a,
    output logic [31:0] fa_b,
    input  logic [31:0] fa_s,
    input  logic        fa_ovf,

    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_s,
    output logic        rsp_ovf,
    output logic        busy
);

    // r_prio = 1 means requester 1 wins a tie
    logic        r_prio;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc;
    logic [31:0] w_acc_a;
    logic [31:0] w_acc_b;

    logic [31:0] r_fa_a;
    logic [31:0] r_fa_b;
    logic [LAT:0] r_tag_v;
    logic [LAT:0] r_tag_id;

    logic        r_rsp0_v;
    logic        r_rsp1_v;
    logic [31:0] r_rsp_s;
    logic        r_rsp_ovf;

    // Grants are gated by rst_n so nothing is handed out while in reset
    assign w_gnt0  = rst_n & req0_valid & (~req1_valid | ~r_prio);
    assign w_gnt1  = rst_n & req1_valid & (~req0_valid |  r_prio);
    assign w_acc   = w_gnt0 | w_gnt1;
    assign w_acc_a = w_gnt1 ? req1_a : req0_a;
    assign w_acc_b = w_gnt1 ? {req1_b[31] ^ req1_sub, req1_b[30:0]}
                            : {req0_b[31] ^ req0_sub, req0_b[30:0]};

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
            r_fa_a <= 32'd0;
            r_fa_b <= 32'd0;
        end else if (w_acc) begin
            r_prio <= w_gnt0;
            r_fa_a <= w_acc_a;
            r_fa_b <= w_acc_b;
        end
    end

    // Tag stage LAT lines up with the adder result appearing on fa_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v  <= {r_tag_v[LAT-1:0],  w_acc};
            r_tag_id <= {r_tag_id[LAT-1:0], w_gnt1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_v  <= 1'b0;
            r_rsp1_v  <= 1'b0;
            r_rsp_s   <= 32'd0;
            r_rsp_ovf <= 1'b0;
        end else begin
            r_rsp0_v <= r_tag_v[LAT] & ~r_tag_id[LAT];
            r_rsp1_v <= r_tag_v[LAT] &  r_tag_id[LAT];
            if (r_tag_v[LAT]) begin
                r_rsp_s   <= fa_s;
                r_rsp_ovf <= fa_ovf;
            end
        end
    end

    assign fa_a       = r_fa_a;
    assign fa_b       = r_fa_b;
    assign rsp0_valid = r_rsp0_v;
    assign rsp1_valid = r_rsp1_v;
    assign rsp_s      = r_rsp_s;
    assign rsp_ovf    = r_rsp_ovf;
    assign busy       = |r_tag_v;

endmodule
`default_nettype wire

// File: doc/float_add_arb.md
FLOAT_ADD_ARB -- requirements
Module: float_add_arb

Interface
REQ-001 The block SHALL have parameter LAT, default 3, meaning the clock edges from operands on fa_a/fa_b to the matching result on fa_s/fa_ovf (legal range 1..8).
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  IEEE-754 single-precision operand A.
- req0_b  in  32  IEEE-754 single-precision operand B.
- req0_sub  in  1  1 = A-B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions, widths and meanings, for requester 1.
- fa_a  out  32  operand A to the shared pipelined float adder.
- fa_b  out  32  operand B to the shared pipelined float adder.
- fa_s  in  32  adder sum.
- fa_ovf  in  1  adder overflow.
- rsp0_valid  out  1  one-cycle result pulse for requester 0.
- rsp1_valid  out  1  one-cycle result pulse for requester 1.
- rsp_s  out  32  result word, shared by both requesters.
- rsp_ovf  out  1  overflow flag, shared by both requesters.
- busy  out  1  at least one operation in flight.

Function
REQ-003 Arbitration SHALL be combinational: at most one of req0_ready/req1_ready high per cycle, only toward a requester with valid high.
REQ-004 A single valid requester SHALL be granted immediately.
REQ-005 If both are valid, the requester not granted most recently SHALL win; the priority pointer SHALL update only on an accepted grant.
REQ-006 An operation SHALL be accepted at the edge where reqN_valid and reqN_ready are both high; the requester SHALL hold its operands until then.
REQ-007 At the accept edge, fa_a SHALL register reqN_a, and fa_b SHALL register reqN_b with bit 31 inverted when reqN_sub=1, else unchanged.
REQ-008 With no accept, fa_a and fa_b SHALL hold their previous values.
REQ-009 A tag pipeline of LAT+1 stages SHALL carry {valid, requester id} alongside each accepted operation; one acceptance per cycle (throughput 1) SHALL be supported.
REQ-010 When a tag reaches its final stage, rsp_s/rsp_ovf SHALL register fa_s/fa_ovf, and rspN_valid SHALL pulse high for exactly one cycle for the tagged requester.
REQ-011 Latency SHALL be fixed: rspN_valid is high in the cycle following the (LAT+1)th rising edge after the accept edge.
REQ-012 Results SHALL return in acceptance order; the two rsp valids SHALL never be high together.
REQ-013 rsp_s/rsp_ovf SHALL hold their last value when no rsp valid is high.
REQ-014 busy SHALL equal the OR of all tag-pipeline valid bits.
REQ-015 A new acceptance in the same cycle a result retires SHALL be legal, with no stall.
REQ-016 There SHALL be no backpressure on responses; requesters SHALL always sink results.
REQ-017 A request whose valid drops before grant SHALL be discarded, with no side effects.

Reset
REQ-018 On rst_n low, asynchronously: fa_a, fa_b, rsp_s = 0; rsp_ovf, rsp0_valid, rsp1_valid, busy = 0; all tag valids = 0; priority pointer favours requester 0.
REQ-019 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-020 Operations in flight at reset SHALL be dropped, with no response pulses after reset release.
REQ-021 Acceptance SHALL resume on the first rising edge after rst_n deasserts.

Verification (LAT=3, behavioural float_add model)
REQ-022 Single add: req0 a=0x3F800000, b=0x40000000, sub=0 -> req0_ready same cycle; fa_b=0x40000000; rsp0_valid one cycle after 4th edge; rsp_s=0x40400000.
REQ-023 Subtract: req1 a=0x40400000, b=0x3F800000, sub=1 -> fa_b=0xBF800000; rsp1_valid only; rsp_s=0x40000000; rsp0_valid stays 0.
REQ-024 Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; back-to-back rsp pulses in the same order, one per cycle.
REQ-025 Overflow: a=b=0x7F7FFFFF add -> rsp_ovf=1 together with the rsp valid.
REQ-026 Reset mid-flight: accept 2 ops, assert rst_n low 2 cycles later -> all outputs 0 immediately; no rsp pulse for 10 cycles after release.
REQ-027 Valid withdrawn: req1_valid pulses while req0 holds the grant under priority -> req1 never accepted; no rsp1 pulse.
